// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes MIPS opcode/funct into ALU control and operands, registered for EX.
// Optional performance counters (perf_issued, perf_bubbles) are built when ISSUE_PERF_CNT_EN is defined.
module alu_issue_stage #(
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [4:0]       shamt,
    input  logic [15:0]      imm16,
    input  logic [DW-1:0]    rs_data,
    input  logic [DW-1:0]    rt_data,
    input  logic             stall,
    input  logic             flush,
    output logic             ex_valid,
    output logic [DW-1:0]    Ain,
    output logic [DW-1:0]    Bin,
    output logic [3:0]       ALUControl,
`ifdef ISSUE_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_issued,
    output logic [CNT_W-1:0] perf_bubbles,
`endif
    output logic             ex_illegal
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;
    localparam logic [3:0] ALU_BEQ = 4'b1001;
    localparam logic [3:0] ALU_BNE = 4'b1010;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Handshake: an ID instruction transfers on a posedge where in_valid && in_ready;
    // a simultaneous flush still consumes it but loads a bubble in its place.
    assign in_ready = ~stall;

    logic          dec_legal;
    logic [3:0]    dec_ctrl;
    logic [DW-1:0] dec_a;
    logic [DW-1:0] dec_b;
    logic [DW-1:0] imm_sext;
    logic [DW-1:0] imm_zext;

    assign imm_sext = {{(DW-16){imm16[15]}}, imm16};
    assign imm_zext = {{(DW-16){1'b0}}, imm16};

    // Illegal encodings fall out with the bubble operand/control values (add, 0, 0).
    always_comb begin
        dec_legal = 1'b0;
        dec_ctrl  = ALU_ADD;
        dec_a     = '0;
        dec_b     = '0;
        case (opcode)
            6'b000000: begin
                dec_legal = 1'b1;
                dec_a     = rs_data;
                dec_b     = rt_data;
                case (funct)
                    6'b100000, 6'b100001: dec_ctrl = ALU_ADD;
                    6'b100010, 6'b100011: dec_ctrl = ALU_SUB;
                    6'b100100:            dec_ctrl = ALU_AND;
                    6'b100101:            dec_ctrl = ALU_OR;
                    6'b100110:            dec_ctrl = ALU_XOR;
                    6'b100111:            dec_ctrl = ALU_NOR;
                    6'b101010:            dec_ctrl = ALU_SLT;
                    6'b000000: begin dec_ctrl = ALU_SLL; dec_a = '0; dec_a[4:0] = shamt; end
                    6'b000010: begin dec_ctrl = ALU_SRL; dec_a = '0; dec_a[4:0] = shamt; end
                    6'b000011: begin dec_ctrl = ALU_SRA; dec_a = '0; dec_a[4:0] = shamt; end
                    6'b000100: begin dec_ctrl = ALU_SLL; dec_a = '0; dec_a[4:0] = rs_data[4:0]; end
                    6'b000110: begin dec_ctrl = ALU_SRL; dec_a = '0; dec_a[4:0] = rs_data[4:0]; end
                    6'b000111: begin dec_ctrl = ALU_SRA; dec_a = '0; dec_a[4:0] = rs_data[4:0]; end
                    default: begin
                        dec_legal = 1'b0;
                        dec_a     = '0;
                        dec_b     = '0;
                    end
                endcase
            end
            6'b001000, 6'b001001, 6'b100011, 6'b101011: begin
                dec_legal = 1'b1; dec_ctrl = ALU_ADD; dec_a = rs_data; dec_b = imm_sext;
            end
            6'b001010: begin dec_legal = 1'b1; dec_ctrl = ALU_SLT; dec_a = rs_data; dec_b = imm_sext; end
            6'b001100: begin dec_legal = 1'b1; dec_ctrl = ALU_AND; dec_a = rs_data; dec_b = imm_zext; end
            6'b001101: begin dec_legal = 1'b1; dec_ctrl = ALU_OR;  dec_a = rs_data; dec_b = imm_zext; end
            6'b001110: begin dec_legal = 1'b1; dec_ctrl = ALU_XOR; dec_a = rs_data; dec_b = imm_zext; end
            6'b000100: begin dec_legal = 1'b1; dec_ctrl = ALU_BEQ; dec_a = rs_data; dec_b = rt_data; end
            6'b000101: begin dec_legal = 1'b1; dec_ctrl = ALU_BNE; dec_a = rs_data; dec_b = rt_data; end
            default: ;
        endcase
    end

    logic load_bubble;
    logic load_instr;

    assign load_bubble = flush | (~stall & ~in_valid);
    assign load_instr  = ~flush & ~stall & in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_illegal <= 1'b0;
            ALUControl <= ALU_ADD;
            Ain        <= '0;
            Bin        <= '0;
        end else if (load_bubble) begin
            ex_valid   <= 1'b0;
            ex_illegal <= 1'b0;
            ALUControl <= ALU_ADD;
            Ain        <= '0;
            Bin        <= '0;
        end else if (load_instr) begin
            ex_valid   <= 1'b1;
            ex_illegal <= ~dec_legal;
            ALUControl <= dec_ctrl;
            Ain        <= dec_a;
            Bin        <= dec_b;
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued  <= '0;
            perf_bubbles <= '0;
        end else begin
            if (load_instr && dec_legal) perf_issued <= perf_issued + 1'b1;
            if (load_bubble) perf_bubbles <= perf_bubbles + 1'b1;
        end
    end
`else
    // Counter width only matters when the counters are built.
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage; define ISSUE_PERF_CNT_EN to also exercise the counters (CNT_W=4).
module tb_alu_issue_stage;

`ifdef ISSUE_PERF_CNT_EN
    localparam int TB_CNT_W = 4;
`else
    localparam int TB_CNT_W = 32;
`endif

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        in_valid, in_ready, stall, flush;
    logic [5:0]  opcode, funct;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [31:0] rs_data, rt_data;
    logic        ex_valid, ex_illegal;
    logic [31:0] Ain, Bin;
    logic [3:0]  ALUControl;
`ifdef ISSUE_PERF_CNT_EN
    logic [TB_CNT_W-1:0] perf_issued, perf_bubbles;
`endif

    alu_issue_stage #(.DW(32), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .shamt(shamt), .imm16(imm16),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .Ain(Ain), .Bin(Bin), .ALUControl(ALUControl),
`ifdef ISSUE_PERF_CNT_EN
        .perf_issued(perf_issued), .perf_bubbles(perf_bubbles),
`endif
        .ex_illegal(ex_illegal)
    );

    int checks = 0;
    int errors = 0;

    logic [69:0] obs;
    assign obs = {ex_valid, ex_illegal, ALUControl, Ain, Bin};

    localparam logic [69:0] BUBBLE = {1'b0, 1'b0, 4'b0010, 32'h0, 32'h0};

    function automatic logic [69:0] ev(input logic v, input logic il, input logic [3:0] c,
                                       input logic [31:0] a, input logic [31:0] b);
        return {v, il, c, a, b};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
        in_valid = 1'b1; opcode = op; funct = fn; shamt = sh; imm16 = imm;
        rs_data = rs; rt_data = rt;
    endtask

    task automatic idle();
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; idle(); drive(6'h08, 6'h00, 5'd0, 16'h0001, 32'h1, 32'h2); in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs !== BUBBLE) begin errors++; $display("FAIL reset_initial: got %h expected %h", obs, BUBBLE); end
        tick(); tick();
        checks++;
        if (obs !== BUBBLE) begin errors++; $display("FAIL reset_held: got %h expected %h", obs, BUBBLE); end
        rst = 1'b0;
        // First capture right after reset release, then async reset mid-cycle
        drive(6'h08, 6'h00, 5'd0, 16'h0004, 32'h7, 32'h0);
        tick();
        checks++;
        if (obs !== ev(1, 0, 4'b0010, 32'h7, 32'h4)) begin
            errors++; $display("FAIL first_capture: got %h expected %h", obs, ev(1, 0, 4'b0010, 32'h7, 32'h4));
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== BUBBLE) begin errors++; $display("FAIL reset_async_midrun: got %h expected %h", obs, BUBBLE); end
        tick();
        rst = 1'b0; idle();
    endtask

    task automatic test_itype();
        logic [5:0]  ops[8]   = '{6'h08, 6'h09, 6'h23, 6'h2B, 6'h0A, 6'h0C, 6'h0D, 6'h0E};
        logic [3:0]  ctrls[8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0111, 4'b0000, 4'b0001, 4'b0011};
        logic        sx[8]    = '{1, 1, 1, 1, 1, 0, 0, 0};
        logic [15:0] imms[2]  = '{16'hFFFF, 16'h1234};
        logic [69:0] e;
        logic [31:0] b;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 8; i++) begin
                drive(ops[i], 6'h3F, 5'd9, imms[j], 32'h5, 32'hDEADBEEF);
                tick();
                b = sx[i] ? {{16{imms[j][15]}}, imms[j]} : {16'h0, imms[j]};
                e = ev(1, 0, ctrls[i], 32'h5, b);
                checks++;
                if (obs !== e) begin errors++; $display("FAIL itype op=%h imm=%h: got %h expected %h", ops[i], imms[j], obs, e); end
            end
        end
        idle();
    endtask

    task automatic test_rtype();
        logic [5:0] fns[9]   = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
        logic [3:0] ctrls[9] = '{4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b1100, 4'b0111};
        logic [69:0] e;
        for (int i = 0; i < 9; i++) begin
            drive(6'h00, fns[i], 5'd17, 16'hAAAA, 32'h12345678, 32'h0F0F0F0F);
            tick();
            e = ev(1, 0, ctrls[i], 32'h12345678, 32'h0F0F0F0F);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL rtype fn=%h: got %h expected %h", fns[i], obs, e); end
        end
        idle();
    endtask

    task automatic test_shift();
        logic [5:0] fns[6]   = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
        logic [3:0] ctrls[6] = '{4'b0100, 4'b0101, 4'b1000, 4'b0100, 4'b0101, 4'b1000};
        logic [31:0] as[6]   = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3};
        logic [69:0] e;
        for (int i = 0; i < 6; i++) begin
            // shamt=3 for immediate shifts; rs[4:0]=3 (rs=0x23) for variable shifts
            drive(6'h00, fns[i], 5'd3, 16'h0000, 32'hFFFFFF23, 32'h80000000);
            if (i < 3) rs_data = 32'h00000023;
            else shamt = 5'd30;
            tick();
            e = ev(1, 0, ctrls[i], as[i], 32'h80000000);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL shift fn=%h: got %h expected %h", fns[i], obs, e); end
        end
        idle();
    endtask

    task automatic test_stall();
        logic [69:0] e_beq, e_add;
        e_beq = ev(1, 0, 4'b1001, 32'hA, 32'hB);
        e_add = ev(1, 0, 4'b0010, 32'h1, 32'h2);
        drive(6'h04, 6'h00, 5'd0, 16'h0010, 32'hA, 32'hB);
        tick();
        checks++;
        if (obs !== e_beq) begin errors++; $display("FAIL beq_issue: got %h expected %h", obs, e_beq); end
        drive(6'h00, 6'h20, 5'd0, 16'h0, 32'h1, 32'h2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
            tick();
            checks++;
            if (obs !== e_beq) begin errors++; $display("FAIL stall_hold cycle %0d: got %h expected %h", i, obs, e_beq); end
        end
        stall = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL unstall_in_ready: got %b expected 1", in_ready); end
        tick();
        checks++;
        if (obs !== e_add) begin errors++; $display("FAIL stall_release: got %h expected %h", obs, e_add); end
        // async reset while stalled
        stall = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== BUBBLE) begin errors++; $display("FAIL reset_mid_stall: got %h expected %h", obs, BUBBLE); end
        tick();
        rst = 1'b0; idle();
    endtask

    task automatic test_flush_illegal();
        logic [69:0] e_ill;
        e_ill = ev(1, 1, 4'b0010, 32'h0, 32'h0);
        drive(6'h05, 6'h00, 5'd0, 16'h0, 32'h33, 32'h44);
        tick();
        checks++;
        if (obs !== ev(1, 0, 4'b1010, 32'h33, 32'h44)) begin
            errors++; $display("FAIL bne_issue: got %h expected %h", obs, ev(1, 0, 4'b1010, 32'h33, 32'h44));
        end
        stall = 1'b1; flush = 1'b1;
        tick();
        checks++;
        if (obs !== BUBBLE) begin errors++; $display("FAIL flush_with_stall: got %h expected %h", obs, BUBBLE); end
        drive(6'h0D, 6'h00, 5'd0, 16'h1, 32'h2, 32'h3);
        tick();
        stall = 1'b0;
        tick();
        checks++;
        if (obs !== BUBBLE) begin errors++; $display("FAIL flush_no_stall: got %h expected %h", obs, BUBBLE); end
        flush = 1'b0;
        drive(6'h3F, 6'h20, 5'd4, 16'hFFFF, 32'h9, 32'h9);
        tick();
        checks++;
        if (obs !== e_ill) begin errors++; $display("FAIL illegal_opcode: got %h expected %h", obs, e_ill); end
        drive(6'h00, 6'h01, 5'd4, 16'hFFFF, 32'h9, 32'h9);
        tick();
        checks++;
        if (obs !== e_ill) begin errors++; $display("FAIL illegal_funct: got %h expected %h", obs, e_ill); end
        idle();
        tick();
        checks++;
        if (obs !== BUBBLE) begin errors++; $display("FAIL idle_bubble: got %h expected %h", obs, BUBBLE); end
    endtask

`ifdef ISSUE_PERF_CNT_EN
    task automatic test_perf();
        idle();
        rst = 1'b1;
        #2 rst = 1'b0;
        drive(6'h08, 6'h00, 5'd0, 16'h1, 32'h1, 32'h0);
        for (int i = 0; i < 17; i++) tick();
        checks++;
        if (perf_issued !== 4'd1 || perf_bubbles !== 4'd0) begin
            errors++; $display("FAIL perf_wrap: got %0d/%0d expected 1/0", perf_issued, perf_bubbles);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (perf_issued !== 4'd1 || perf_bubbles !== 4'd0) begin
            errors++; $display("FAIL perf_stall: got %0d/%0d expected 1/0", perf_issued, perf_bubbles);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        tick(); tick();
        opcode = 6'h3F; in_valid = 1'b1;
        tick();
        checks++;
        if (perf_issued !== 4'd1 || perf_bubbles !== 4'd3) begin
            errors++; $display("FAIL perf_bubbles: got %0d/%0d expected 1/3", perf_issued, perf_bubbles);
        end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_itype();
        test_rtype();
        test_shift();
        test_stall();
        test_flush_illegal();
`ifdef ISSUE_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
